// File: rtl/key_schedule_ctrl_pkg.sv
// Shared types and constants for the AES-128 key schedule controller.
// The controller sequences an external round unit; this package holds the FSM encoding and rcon arithmetic.
package key_schedule_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_STORE,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int         NROUNDS   = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;

    // Multiply by x in GF(2^8), the step between successive round constants
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return v[7] ? ({v[6:0], 1'b0} ^ RCON_POLY) : {v[6:0], 1'b0};
    endfunction

endpackage

// File: rtl/key_schedule_ctrl_store.sv
// Round-key register file: one write port, a gated user read port and a raw read port
// that feeds the previous round key to the round unit.
module round_key_store #(
    parameter int NSLOTS = 11
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear,
    input  logic         wr_en,
    input  logic [3:0]   wr_idx,
    input  logic [127:0] wr_data,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_data,
    output logic         rd_valid,
    input  logic [3:0]   prev_idx,
    output logic [127:0] prev_data
);

    localparam logic [3:0] LAST = 4'(NSLOTS - 1);

    logic [127:0]      mem [NSLOTS];
    logic [NSLOTS-1:0] valid;

    // Key data is never cleared; only the valid bits carry reset meaning
    always_ff @(posedge clk_i) begin
        if (wr_en && wr_idx <= LAST) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // A clear and a write in the same cycle leave only the written slot valid
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid <= '0;
        end else begin
            if (clear) begin
                valid <= '0;
            end
            if (wr_en && wr_idx <= LAST) begin
                valid[wr_idx] <= 1'b1;
            end
        end
    end

    assign rd_valid  = (rd_idx <= LAST) && valid[rd_idx];
    assign rd_data   = rd_valid ? mem[rd_idx] : '0;
    assign prev_data = mem[prev_idx];

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 key expansion sequencer: issues each round to an external G-function unit,
// captures its result on a ready rising edge and stores it, with a per-round watchdog.
module key_schedule_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int NROUNDS = key_schedule_ctrl_pkg::NROUNDS
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic [127:0]                  key_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          error_o,
    input  logic [3:0]                    rk_idx_i,
    output logic [127:0]                  rk_o,
    output logic                          rk_valid_o,
    output logic                          unit_en_o,
    output logic [31:0]                   unit_word_o,
    output logic [127:0]                  unit_key_o,
    output logic [7:0]                    unit_rcon_o,
    input  logic                          unit_ready_i,
    input  logic [127:0]                  unit_key_i,
    output key_schedule_ctrl_pkg::state_t dbg_state
);

    import key_schedule_ctrl_pkg::*;

    // Handshake: unit_en_o rises in ISSUE and stays high with unit_key_o/unit_word_o/unit_rcon_o
    // stable until the unit raises unit_ready_i (a low-to-high transition seen during WAIT);
    // unit_key_i is captured on that edge and a ready level left high from an earlier round is ignored.

    localparam int               WD_W       = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_LIMIT   = WD_W'(TIMEOUT - 1);
    localparam logic [3:0]       LAST_ROUND = 4'(NROUNDS);

    state_t            state, state_nx;
    logic [3:0]        round;
    logic [7:0]        rcon;
    logic [WD_W-1:0]   wdog;
    logic              ready_q;
    logic              ready_edge;
    logic              error_q;
    logic              accept;
    logic [127:0]      cap_key;
    logic [127:0]      prev_key;
    logic [3:0]        prev_idx;
    logic              wr_en;
    logic [3:0]        wr_idx;
    logic [127:0]      wr_data;

    assign ready_edge = unit_ready_i & ~ready_q;
    assign accept     = start_i && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: if (start_i) state_nx = ST_LOAD;
            ST_LOAD:  state_nx = ST_ISSUE;
            ST_ISSUE: state_nx = ST_WAIT;
            ST_WAIT: begin
                // A capture on the expiry cycle takes precedence over the timeout
                if (ready_edge) begin
                    state_nx = ST_STORE;
                end else if (wdog == WD_LIMIT) begin
                    state_nx = ST_ERR;
                end
            end
            ST_STORE: state_nx = (round == LAST_ROUND) ? ST_DONE : ST_LOAD;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            round   <= '0;
            rcon    <= RCON_INIT;
            wdog    <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state   <= state_nx;
            ready_q <= unit_ready_i;
            if (accept) begin
                round   <= 4'd1;
                rcon    <= RCON_INIT;
                error_q <= 1'b0;
            end
            if (state == ST_ISSUE) begin
                wdog <= '0;
            end else if (state == ST_WAIT) begin
                wdog <= wdog + 1'b1;
            end
            if (state == ST_STORE && round != LAST_ROUND) begin
                round <= round + 4'd1;
                rcon  <= xtime(rcon);
            end
            if (state == ST_WAIT && state_nx == ST_ERR) begin
                error_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (state == ST_WAIT && ready_edge) begin
            cap_key <= unit_key_i;
        end
    end

    // Slot 0 takes the cipher key on start; later slots take the captured unit result
    assign wr_en    = accept || (state == ST_STORE);
    assign wr_idx   = accept ? 4'd0 : round;
    assign wr_data  = accept ? key_i : cap_key;
    assign prev_idx = (round == 4'd0) ? 4'd0 : round - 4'd1;

    round_key_store #(
        .NSLOTS(NROUNDS + 1)
    ) u_store (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear    (accept),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .rd_idx   (rk_idx_i),
        .rd_data  (rk_o),
        .rd_valid (rk_valid_o),
        .prev_idx (prev_idx),
        .prev_data(prev_key)
    );

    assign busy_o      = (state == ST_LOAD) || (state == ST_ISSUE) ||
                         (state == ST_WAIT) || (state == ST_STORE);
    assign done_o      = (state == ST_DONE);
    assign error_o     = error_q;
    assign unit_en_o   = (state == ST_ISSUE) || (state == ST_WAIT);
    assign unit_key_o  = prev_key;
    assign unit_word_o = prev_key[31:0];
    assign unit_rcon_o = rcon;
    assign dbg_state   = state;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl: behavioural AES round unit with programmable latency/hold,
// timing-level reference model checked every cycle, plus FIPS-197 literal pins.
module tb_key_schedule_ctrl;
    import key_schedule_ctrl_pkg::*;

    localparam int NR      = 10;
    localparam int TIMEOUT = 64;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk_i = 1'b0;
    logic         rst_i, start_i, unit_ready_i;
    logic [127:0] key_i, unit_key_i;
    logic [3:0]   rk_idx_i;
    logic         busy_o, done_o, error_o, rk_valid_o, unit_en_o;
    logic [127:0] rk_o, unit_key_o;
    logic [31:0]  unit_word_o;
    logic [7:0]   unit_rcon_o;
    state_t       dbg_state;

    key_schedule_ctrl #(.TIMEOUT(TIMEOUT), .NROUNDS(NR)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .key_i(key_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .rk_idx_i(rk_idx_i), .rk_o(rk_o), .rk_valid_o(rk_valid_o),
        .unit_en_o(unit_en_o), .unit_word_o(unit_word_o), .unit_key_o(unit_key_o),
        .unit_rcon_o(unit_rcon_o), .unit_ready_i(unit_ready_i), .unit_key_i(unit_key_i),
        .dbg_state(dbg_state)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_on = 0;
    logic [7:0] sbox_t [256];
    logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    // Reference model: mode 0 = idle after reset, 1 = expansion that completes, 2 = expansion that times out
    int m_mode = 0;
    int m_n = 0;
    int m_lat = 4;
    logic [127:0] m_keys [11];

    int unit_lat = 4;
    int unit_hold = 1;
    int en_cnt = 0;
    int hold_left = 0;
    logic [7:0] cap_q [$];
    int stores = 0;
    logic ready_prev = 1'b0;
    logic en_prev = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] v);
        logic [7:0] inv;
        inv = 8'h00;
        if (v != 8'h00) begin
            inv = 8'h01;
            for (int j = 0; j < 254; j++) inv = gmul(inv, v);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // One AES-128 expansion step; w3 is the word rotated through the S-box
    function automatic logic [127:0] next_key_w(input logic [127:0] k, input logic [31:0] w3,
                                                input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3n;
        t = {w3[23:0], w3[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3n = k[31:0] ^ w2;
        return {w0, w1, w2, w3n};
    endfunction

    function automatic bit exp_busy();
        if (m_mode == 1) return m_n <= NR * (3 + m_lat);
        if (m_mode == 2) return m_n <= 2 + TIMEOUT;
        return 1'b0;
    endfunction

    function automatic bit exp_done();
        return (m_mode == 1) && (m_n >= NR * (3 + m_lat) + 1);
    endfunction

    function automatic bit exp_err();
        return (m_mode == 2) && (m_n >= 3 + TIMEOUT);
    endfunction

    function automatic bit exp_en();
        int per, ph;
        per = 3 + m_lat;
        ph = (m_n - 1) % per;
        if (m_mode == 1) return (m_n <= NR * per) && (ph >= 1) && (ph <= m_lat + 1);
        if (m_mode == 2) return (m_n >= 2) && (m_n <= 2 + TIMEOUT);
        return 1'b0;
    endfunction

    function automatic logic [7:0] exp_rcon();
        int r;
        if (m_mode == 0) return 8'h01;
        if (m_mode == 2) return rcon_tab[0];
        r = (m_n - 1) / (3 + m_lat);
        if (r > NR - 1) r = NR - 1;
        return rcon_tab[r];
    endfunction

    function automatic bit exp_valid(input int idx);
        if (m_mode == 0 || idx > NR) return 1'b0;
        if (idx == 0) return 1'b1;
        if (m_mode == 2) return 1'b0;
        return m_n >= idx * (3 + m_lat) + 1;
    endfunction

    // Model advance: decides acceptance from its own view of idle/done/error
    always @(posedge clk_i) begin
        if (rst_i) begin
            m_mode = 0;
            m_n = 0;
        end else if (start_i && (m_mode == 0 || exp_done() || exp_err())) begin
            m_lat = unit_lat;
            m_mode = (unit_lat > TIMEOUT) ? 2 : 1;
            m_n = 1;
            m_keys[0] = key_i;
            for (int r = 1; r <= NR; r++)
                m_keys[r] = next_key_w(m_keys[r-1], m_keys[r-1][31:0], rcon_tab[r-1]);
        end else if (m_mode != 0) begin
            m_n++;
        end
    end

    // Behavioural round unit: ready rises unit_lat cycles after enable and stays high unit_hold cycles
    always @(posedge clk_i) begin
        #1;
        if (unit_en_o) en_cnt++;
        else en_cnt = 0;
        if (unit_en_o && en_cnt == unit_lat + 1) hold_left = unit_hold;
        else if (hold_left > 0) hold_left--;
        unit_ready_i = (hold_left > 0);
        unit_key_i = unit_ready_i ? next_key_w(unit_key_o, unit_word_o, unit_rcon_o)
                                  : {$urandom(), $urandom(), $urandom(), $urandom()};
    end

    always @(negedge clk_i) begin
        if (unit_en_o && unit_ready_i && !ready_prev) cap_q.push_back(unit_rcon_o);
        if (busy_o && en_prev && !unit_en_o) stores++;
        ready_prev = unit_ready_i;
        en_prev = unit_en_o;
    end

    // Per-cycle compare against the model
    always @(negedge clk_i) begin
        if (chk_on) begin
            chk("busy", 128'(busy_o), 128'(exp_busy()));
            chk("done", 128'(done_o), 128'(exp_done()));
            chk("error", 128'(error_o), 128'(exp_err()));
            chk("unit_en", 128'(unit_en_o), 128'(exp_en()));
            if (exp_en() || m_mode == 0) chk("unit_rcon", 128'(unit_rcon_o), 128'(exp_rcon()));
            chk("rk_valid", 128'(rk_valid_o), 128'(exp_valid(int'(rk_idx_i))));
            if (exp_valid(int'(rk_idx_i))) chk("rk", rk_o, m_keys[rk_idx_i]);
            else chk("rk_zero", rk_o, 128'h0);
        end
    end

    task automatic run(input logic [127:0] k, input int lat, input int hold, input bit junk,
                       output int cycles);
        unit_lat = lat;
        unit_hold = hold;
        @(posedge clk_i); #2;
        start_i = 1'b1;
        key_i = k;
        @(posedge clk_i); #2;
        start_i = 1'b0;
        key_i = {$urandom(), $urandom(), $urandom(), $urandom()};
        cycles = 1;
        chk("err_cleared", 128'(error_o), 128'h0);
        while (!(done_o || error_o) && cycles < 2000) begin
            start_i = (junk && exp_busy() && $urandom_range(0, 3) == 0);
            rk_idx_i = 4'($urandom_range(0, 15));
            @(posedge clk_i); #2;
            cycles++;
        end
        start_i = 1'b0;
        chk("run_end", 128'(done_o | error_o), 128'h1);
    endtask

    logic [127:0] tmp_k;
    int cyc, lat, hold, guard;

    initial begin
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
        rst_i = 1'b1; start_i = 1'b0; key_i = '0; rk_idx_i = '0;
        unit_ready_i = 1'b0; unit_key_i = '0;
        repeat (3) @(posedge clk_i);
        #2;
        chk_on = 1;
        chk("rst_busy", 128'(busy_o), 128'h0);
        chk("rst_done", 128'(done_o), 128'h0);
        chk("rst_en", 128'(unit_en_o), 128'h0);
        chk("rst_rcon", 128'(unit_rcon_o), 128'h01);
        chk("rst_rk", rk_o, 128'h0);
        chk("rst_rk_valid", 128'(rk_valid_o), 128'h0);
        rst_i = 1'b0;

        // Pin the reference expansion itself to FIPS-197
        tmp_k = next_key_w(FIPS_KEY, FIPS_KEY[31:0], rcon_tab[0]);
        chk("model_rk1", tmp_k, FIPS_RK1);
        for (int r = 2; r <= NR; r++) tmp_k = next_key_w(tmp_k, tmp_k[31:0], rcon_tab[r-1]);
        chk("model_rk10", tmp_k, FIPS_RK10);

        // FIPS key, L=4: latency and rcon order at each capture
        cap_q.delete();
        stores = 0;
        run(FIPS_KEY, 4, 1, 0, cyc);
        chk("latency_fips", 128'(cyc), 128'd71);
        chk("rcon_count", 128'(cap_q.size()), 128'd10);
        for (int i = 0; i < cap_q.size() && i < 10; i++) chk("rcon_seq", 128'(cap_q[i]), 128'(rcon_tab[i]));
        chk("stores_fips", 128'(stores), 128'd10);
        rk_idx_i = 4'd1; #1;
        chk("rk1_fips", rk_o, FIPS_RK1);
        rk_idx_i = 4'd10; #1;
        chk("rk10_fips", rk_o, FIPS_RK10);

        // Stray start pulses while busy must be ignored
        run(FIPS_KEY, 4, 1, 1, cyc);
        chk("latency_junk", 128'(cyc), 128'd71);
        rk_idx_i = 4'd1; #1;
        chk("rk1_junk", rk_o, FIPS_RK1);
        rk_idx_i = 4'd10; #1;
        chk("rk10_junk", rk_o, FIPS_RK10);
        rk_idx_i = 4'd12; #1;
        chk("rk12_zero", rk_o, 128'h0);
        chk("rk12_invalid", 128'(rk_valid_o), 128'h0);

        // Ready held 2 cycles, and held long enough to straddle into the next WAIT
        stores = 0;
        run({$urandom(), $urandom(), $urandom(), $urandom()}, 4, 2, 0, cyc);
        chk("latency_hold2", 128'(cyc), 128'd71);
        chk("stores_hold2", 128'(stores), 128'd10);
        run({$urandom(), $urandom(), $urandom(), $urandom()}, 4, 6, 0, cyc);
        chk("latency_hold6", 128'(cyc), 128'd71);

        // Random latency / hold / stray starts
        for (int t = 0; t < 6; t++) begin
            lat = $urandom_range(1, 8);
            hold = $urandom_range(1, lat + 2);
            run({$urandom(), $urandom(), $urandom(), $urandom()}, lat, hold, 1'b1, cyc);
            chk("latency_rand", 128'(cyc), 128'(NR * (3 + lat) + 1));
        end

        // Ready edge on the watchdog's last cycle: capture wins
        run({$urandom(), $urandom(), $urandom(), $urandom()}, TIMEOUT, 1, 0, cyc);
        chk("latency_edge64", 128'(cyc), 128'd671);
        chk("no_err_edge64", 128'(error_o), 128'h0);

        // Unit never ready, then one cycle too late: timeout 64 cycles after WAIT entry
        run({$urandom(), $urandom(), $urandom(), $urandom()}, 1000, 1, 0, cyc);
        chk("timeout_cycles", 128'(cyc), 128'd67);
        chk("timeout_err", 128'(error_o), 128'h1);
        chk("timeout_busy", 128'(busy_o), 128'h0);
        chk("timeout_en", 128'(unit_en_o), 128'h0);
        run({$urandom(), $urandom(), $urandom(), $urandom()}, TIMEOUT + 1, 1, 0, cyc);
        chk("timeout65_cycles", 128'(cyc), 128'd67);
        run(FIPS_KEY, 4, 1, 0, cyc);
        chk("recover_latency", 128'(cyc), 128'd71);

        // Reset during round 5 WAIT
        unit_lat = 4;
        unit_hold = 1;
        @(posedge clk_i); #2;
        start_i = 1'b1;
        key_i = FIPS_KEY;
        @(posedge clk_i); #2;
        start_i = 1'b0;
        guard = 0;
        while (m_n < 31 && guard < 200) begin
            @(posedge clk_i); #2;
            guard++;
        end
        chk("r5_reached", 128'(m_n), 128'd31);
        chk("r5_en", 128'(unit_en_o), 128'h1);
        chk("r5_rcon", 128'(unit_rcon_o), 128'h10);
        rst_i = 1'b1;
        @(posedge clk_i); #2;
        rst_i = 1'b0;
        chk("rst_mid_state", 128'(dbg_state), 128'(ST_IDLE));
        chk("rst_mid_en", 128'(unit_en_o), 128'h0);
        chk("rst_mid_busy", 128'(busy_o), 128'h0);
        for (int i = 0; i < 16; i++) begin
            rk_idx_i = 4'(i);
            @(negedge clk_i); #1;
            chk("rst_mid_valid", 128'(rk_valid_o), 128'h0);
            chk("rst_mid_rk", rk_o, 128'h0);
        end

        run(FIPS_KEY, 3, 1, 1, cyc);
        chk("after_rst_latency", 128'(cyc), 128'd61);
        rk_idx_i = 4'd10; #1;
        chk("after_rst_rk10", rk_o, FIPS_RK10);

        repeat (3) @(posedge clk_i);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
